// File: rtl/drbg_pkg.sv
// drbg_pkg: shared CTR_DRBG types and helpers for the update and generate blocks
package drbg_pkg;
    localparam int BLK_W = 128;
    typedef enum logic [1:0] {IDLE, REQ, FIN} upd_state_t;
    function automatic int nblk(input int key_w);
        return (key_w + 2 * BLK_W - 1) / BLK_W;
    endfunction
    // Only the low ctr_w bits count; the upper bits of V never see a carry
    function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] v, input int ctr_w);
        logic [BLK_W-1:0] m;
        m = {BLK_W{1'b1}} >> (BLK_W - ctr_w);
        return (v & ~m) | ((v + 1'b1) & m);
    endfunction
endpackage

// File: rtl/ctr_drbg_update_if.sv
// ctr_drbg_update_if: cipher request/response channel between the DRBG update engine and the AES core
interface ctr_drbg_update_if #(parameter int KEY_W = 256);
    import drbg_pkg::*;
    logic             aes_req;
    logic [KEY_W-1:0] aes_key;
    logic [BLK_W-1:0] aes_pt;
    logic             aes_ack;
    logic [BLK_W-1:0] aes_ct;
    modport master (output aes_req, aes_key, aes_pt, input aes_ack, aes_ct);
    modport slave (input aes_req, aes_key, aes_pt, output aes_ack, aes_ct);
endinterface

// File: rtl/drbg_keystream_buf.sv
// drbg_keystream_buf: NBLK x 128 ciphertext buffer loaded by slot; slot 0 is most significant,
// output is the leftmost SEED_W bits
module drbg_keystream_buf
    import drbg_pkg::*;
#(
    parameter int NBLK = 3,
    parameter int SEED_W = 384,
    localparam int IW = $clog2(NBLK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [IW-1:0]     slot,
    input  logic [BLK_W-1:0]  din,
    output logic [SEED_W-1:0] dout
);
    logic [BLK_W-1:0]      slot_q [NBLK];
    logic [NBLK*BLK_W-1:0] flat;

    always_ff @(posedge clk or posedge rst)
        if (rst) slot_q <= '{default: '0};
        else if (load) slot_q[slot] <= din;

    for (genvar s = 0; s < NBLK; s++) begin : g_flat
        assign flat[(NBLK-s)*BLK_W-1 -: BLK_W] = slot_q[s];
    end

    assign dout = flat[NBLK*BLK_W-1 -: SEED_W];
endmodule

// File: rtl/ctr_drbg_update.sv
// ctr_drbg_update: CTR_DRBG Update (no derivation function) holding Key/V and driving an external AES core
module ctr_drbg_update
    import drbg_pkg::*;
#(
    parameter int KEY_W = 256,
    parameter int CTR_W = 128,
    localparam int SEED_W = KEY_W + BLK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              init,
    input  logic [SEED_W-1:0] provided_data,
    output logic [KEY_W-1:0]  key,
    output logic [BLK_W-1:0]  v,
    output logic              busy,
    output logic              done,
    ctr_drbg_update_if.master aes
);
    localparam int NBLK = nblk(KEY_W);
    localparam int IW = $clog2(NBLK);

    upd_state_t        state, state_nx;
    logic [KEY_W-1:0]  wk;
    logic [BLK_W-1:0]  wv;
    logic [SEED_W-1:0] pd_q, temp, mixed;
    logic [IW-1:0]     idx;
    logic              accept, take, last;

    assign accept = state == IDLE && start;
    assign take   = state == REQ && aes.aes_ack;
    assign last   = idx == IW'(NBLK - 1);
    assign mixed  = temp ^ pd_q;

    assign busy        = state != IDLE;
    assign aes.aes_req = state == REQ;
    assign aes.aes_key = wk;
    assign aes.aes_pt  = wv;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (start ? REQ : IDLE) :
                   state == REQ  ? (take && last ? FIN : REQ) : IDLE;
    end

    // The working copies feed the cipher; key/v only move on the FIN edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wk   <= '0;
            wv   <= '0;
            pd_q <= '0;
            idx  <= '0;
            key  <= '0;
            v    <= '0;
            done <= 1'b0;
        end else begin
            done <= state == FIN;
            if (accept) begin
                wk   <= init ? '0 : key;
                wv   <= ctr_inc(init ? '0 : v, CTR_W);
                pd_q <= provided_data;
                idx  <= '0;
            end
            if (take) begin
                wv  <= ctr_inc(wv, CTR_W);
                idx <= idx + 1'b1;
            end
            if (state == FIN) begin
                key <= mixed[SEED_W-1:BLK_W];
                v   <= mixed[BLK_W-1:0];
            end
        end
    end

    drbg_keystream_buf #(.NBLK(NBLK), .SEED_W(SEED_W)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .load (take),
        .slot (idx),
        .din  (aes.aes_ct),
        .dout (temp)
    );
endmodule

// File: tb/tb_ctr_drbg_update.sv
// tb_ctr_drbg_update: directed checks of the Update engine against an XOR cipher model
module tb_ctr_drbg_update;
    localparam logic [127:0] MASK = {4{32'hA5A5A5A5}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] st = '0, ini = '0, dn, bsy;
    logic [383:0] pdv [3] = '{default: '0};
    logic [255:0] key_a, key_b;
    logic [191:0] key_c;
    logic [127:0] v_a, v_b, v_c;

    logic         rq [3];
    logic [127:0] pt [3];
    logic [255:0] ak [3];
    logic         ackv [3];
    logic [127:0] ctv [3];
    int           wt [3];
    logic         hold [3];
    logic [127:0] hpt [3];
    logic [255:0] hak [3];
    int           dly [3] = '{0, -1, -1};
    int           nl [3] = '{0, 0, 0};
    int           dc [3] = '{0, 0, 0};
    logic [127:0] ptl [3][64];
    logic [255:0] akl [3][64];
    int           unstable = 0;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    ctr_drbg_update_if #(.KEY_W(256)) aes_a ();
    ctr_drbg_update_if #(.KEY_W(256)) aes_b ();
    ctr_drbg_update_if #(.KEY_W(192)) aes_c ();

    ctr_drbg_update #(.KEY_W(256), .CTR_W(128)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .init(ini[0]), .provided_data(pdv[0]),
        .key(key_a), .v(v_a), .busy(bsy[0]), .done(dn[0]), .aes(aes_a));
    ctr_drbg_update #(.KEY_W(256), .CTR_W(32)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .init(ini[1]), .provided_data(pdv[1]),
        .key(key_b), .v(v_b), .busy(bsy[1]), .done(dn[1]), .aes(aes_b));
    ctr_drbg_update #(.KEY_W(192), .CTR_W(128)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .init(ini[2]), .provided_data(pdv[2][319:0]),
        .key(key_c), .v(v_c), .busy(bsy[2]), .done(dn[2]), .aes(aes_c));

    assign rq[0] = aes_a.aes_req;
    assign rq[1] = aes_b.aes_req;
    assign rq[2] = aes_c.aes_req;
    assign pt[0] = aes_a.aes_pt;
    assign pt[1] = aes_b.aes_pt;
    assign pt[2] = aes_c.aes_pt;
    assign ak[0] = aes_a.aes_key;
    assign ak[1] = aes_b.aes_key;
    assign ak[2] = {64'b0, aes_c.aes_key};
    assign aes_a.aes_ack = ackv[0];
    assign aes_b.aes_ack = ackv[1];
    assign aes_c.aes_ack = ackv[2];
    assign aes_a.aes_ct = ctv[0];
    assign aes_b.aes_ct = ctv[1];
    assign aes_c.aes_ct = ctv[2];

    function automatic int nw(input int d);
        return d < 0 ? int'($urandom_range(0, 3)) : d;
    endfunction

    // Cipher model: ct = pt ^ MASK after dly wait cycles (random 0..3 when dly < 0)
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (rq[u] && wt[u] == 0) begin
                ackv[u] = 1'b1;
                ctv[u] = pt[u] ^ MASK;
                ptl[u][nl[u] % 64] = pt[u];
                akl[u][nl[u] % 64] = ak[u];
                nl[u]++;
                wt[u] = nw(dly[u]);
            end else begin
                ackv[u] = 1'b0;
                wt[u] = rq[u] ? wt[u] - 1 : nw(dly[u]);
            end
            if (hold[u] && rq[u] && (pt[u] != hpt[u] || ak[u] != hak[u])) unstable++;
            hold[u] = rq[u] && !ackv[u];
            hpt[u] = pt[u];
            hak[u] = ak[u];
            if (dn[u]) dc[u]++;
        end
    end

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input int u, input logic i, input logic [383:0] p, input bit now, output int cyc);
        if (!now) @(negedge clk);
        st[u] = 1'b1;
        ini[u] = i;
        pdv[u] = p;
        @(negedge clk);
        st[u] = 1'b0;
        check("busy", bsy[u], 1);
        cyc = 0;
        while (!dn[u] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", dn[u], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int cyc, b, d0;
        logic [95:0] up;
        logic [127:0] x, v1;
        logic [255:0] k1;
        logic [383:0] full, p;
        logic [319:0] m320;
        repeat (3) @(negedge clk);
        check("rst_key", key_a, 0);
        check("rst_v", v_a, 0);
        check("rst_busy", bsy, 0);
        check("rst_done", dn, 0);
        check("rst_req", rq[0], 0);
        check("rst_aes_key", ak[0], 0);
        check("rst_aes_pt", pt[0], 0);
        rst = 1'b0;

        // 1: instantiate with zero wait
        b = nl[0];
        d0 = dc[0];
        run(0, 1'b1, '0, 1'b0, cyc);
        check("t1_latency", cyc, 4);
        for (int k = 0; k < 3; k++) begin
            check("t1_pt", ptl[0][(b + k) % 64], 128'(k + 1));
            check("t1_aes_key", akl[0][(b + k) % 64], 0);
        end
        check("t1_key", key_a, {MASK ^ 128'd1, MASK ^ 128'd2});
        check("t1_v", v_a, MASK ^ 128'd3);
        @(negedge clk);
        check("t1_done_pulse", dn[0], 0);
        repeat (3) @(negedge clk);
        check("t1_done_once", dc[0] - d0, 1);

        // 2: 32-bit counter wrap keeps the upper 96 bits
        up = 96'h0123456789ABCDEF01234567;
        x = {up, 32'hFFFFFFFE};
        run(1, 1'b1, {256'b0, x ^ MASK ^ 128'd3}, 1'b0, cyc);
        check("t2_setup_v", v_b, x);
        b = nl[1];
        run(1, 1'b0, '0, 1'b0, cyc);
        check("t2_pt0", ptl[1][b % 64], {up, 32'hFFFFFFFF});
        check("t2_pt1", ptl[1][(b + 1) % 64], {up, 32'h00000000});
        check("t2_pt2", ptl[1][(b + 2) % 64], {up, 32'h00000001});
        check("t2_aes_key", akl[1][b % 64], {MASK ^ 128'd1, MASK ^ 128'd2});
        check("t2_key", key_b, {{up, 32'hFFFFFFFF} ^ MASK, {up, 32'h00000000} ^ MASK});
        check("t2_v", v_b, {up, 32'h00000001} ^ MASK);

        // 3: AES-192 truncation of the 384-bit keystream to 320 bits
        b = nl[2];
        run(2, 1'b1, '1, 1'b0, cyc);
        full = {MASK ^ 128'd1, MASK ^ 128'd2, MASK ^ 128'd3};
        m320 = ~full[383:64];
        check("t3_reqs", nl[2] - b, 3);
        check("t3_pt2", ptl[2][(b + 2) % 64], 3);
        check("t3_key", key_c, m320[319:128]);
        check("t3_v", v_c, m320[127:0]);

        // 4: start held high while busy is ignored
        dly[0] = 3;
        b = nl[0];
        d0 = dc[0];
        @(negedge clk);
        st[0] = 1'b1;
        ini[0] = 1'b1;
        pdv[0] = '0;
        @(negedge clk);
        cyc = 0;
        while (bsy[0] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        st[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_one_done", dc[0] - d0, 1);
        check("t4_reqs", nl[0] - b, 3);
        check("t4_key", key_a, {MASK ^ 128'd1, MASK ^ 128'd2});
        check("aes_stable", unstable, 0);

        // 5: reset in REQ after the first ack
        dly[0] = 2;
        b = nl[0];
        d0 = dc[0];
        @(negedge clk);
        st[0] = 1'b1;
        ini[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        cyc = 0;
        while (nl[0] - b < 1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("t5_in_req", rq[0], 1);
        rst = 1'b1;
        #1;
        check("t5_key", key_a, 0);
        check("t5_v", v_a, 0);
        check("t5_req", rq[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_no_done", dc[0] - d0, 0);
        dly[0] = 0;
        b = nl[0];
        run(0, 1'b0, '0, 1'b0, cyc);
        check("t5_aes_key", akl[0][b % 64], 0);
        check("t5_pt0", ptl[0][b % 64], 1);
        check("t5_after_key", key_a, {MASK ^ 128'd1, MASK ^ 128'd2});

        // 6: second Update started in the done cycle
        dly[0] = -1;
        p = {128'h0123456789ABCDEF0011223344556677, 128'h0, 128'h0000000000000000FFFFFFFFFFFFFFFF};
        k1 = {MASK ^ 128'd1, MASK ^ 128'd2} ^ p[383:128];
        v1 = (MASK ^ 128'd3) ^ p[127:0];
        b = nl[0];
        run(0, 1'b1, p, 1'b0, cyc);
        check("t6_key1", key_a, k1);
        check("t6_v1", v_a, v1);
        run(0, 1'b0, '0, 1'b1, cyc);
        check("t6_aes_key", akl[0][(b + 3) % 64], k1);
        check("t6_pt", ptl[0][(b + 3) % 64], v1 + 128'd1);
        check("t6_key2", key_a, {(v1 + 128'd1) ^ MASK, (v1 + 128'd2) ^ MASK});
        check("t6_v2", v_a, (v1 + 128'd3) ^ MASK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
